reel_spinner: RTL and testbench
===============================

# reel_spinner

Three-reel spin engine for the one-arm bandit, sitting directly upstream of the `Score` stage. It free-runs three decimal reels at slightly different rates on a start pulse and freezes them one at a time on stop pulses. For each freeze it emits a stop event (`ref_sign`, `refresh`), and once all three reels are frozen it emits a turn-complete pulse (`turn_p`). `Score` consumes `number1..3` together with these pulses.

## Interface
- `DIV_BASE`, default 2_500_000: clock cycles per digit step for reel 1. Reel 2 uses `DIV_BASE+1`; reel 3 uses `DIV_BASE+2`. Must be ≥ 2.
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `start_p` in 1: one-cycle pulse (debounced button) that starts a spin.
- `stop_p` in 1: one-cycle pulse that stops the next still-spinning reel.
- `number1` out 4: reel 1 digit, 0..9.
- `number2` out 4: reel 2 digit, 0..9.
- `number3` out 4: reel 3 digit, 0..9.
- `refresh` out 2: index of the reel that most recently stopped (1..3); 0 means none since start.
- `ref_sign` out 1: one-cycle pulse; a reel has just stopped.
- `turn_p` out 1: one-cycle pulse; all three reels are stopped and the turn is complete.
- `busy` out 1: high while any reel is spinning.

## Operation
- **Reset values:** every output is 0. The FSM goes to IDLE and all divider counters go to 0.
- **FSM states:** IDLE → SPIN3 → SPIN2 → SPIN1 → DONE → IDLE.
  - IDLE + `start_p` → SPIN3. Divider counters are cleared, `refresh` is cleared to 0, and digits keep their current values.
  - SPIN3 + `stop_p` → SPIN2: reel 1 freezes.
  - SPIN2 + `stop_p` → SPIN1: reel 2 freezes.
  - SPIN1 + `stop_p` → DONE: reel 3 freezes.
  - DONE → IDLE unconditionally after one cycle.
- **Reel stepping:** each spinning reel k has a counter `cnt_k`.
  - `cnt_k` increments every cycle.
  - When `cnt_k == DIV_k-1`, it wraps to 0 and the digit steps 9→0 with wrap.
  - Counter width is `$clog2(DIV_BASE+3)`.
  - A frozen reel holds both its digit and its counter.
- **Stop priority:** at the edge that samples `stop_p`, the stopped reel does not step, even if its tick coincides.
- **Stop event:** at that same edge, `ref_sign` is set to 1 and `refresh` is set to k. `ref_sign` returns to 0 the following edge. `refresh` holds k until the next stop or the next start.
- **Turn complete:** `turn_p` is asserted at the edge leaving DONE. That is exactly one cycle after the third `ref_sign`. Digits are stable by then.
- **`busy`:** 1 in SPIN3/SPIN2/SPIN1, 0 in IDLE and DONE.
- **Ignored and simultaneous inputs:**
  - `start_p` is ignored outside IDLE.
  - `stop_p` is ignored in IDLE and DONE.
  - `start_p` and `stop_p` together in IDLE: start wins and the stop is dropped.
  - `start_p` and `stop_p` together in a SPIN state: the stop is applied.
- **Reset mid-spin:** all state and outputs return to reset values at that edge. No `ref_sign` or `turn_p` is emitted.
- **Digit stability:** digits change only on reel ticks and never exceed 9.

## Timing
- All outputs are registered; there is no combinational input→output path.
- Start sampled at edge S:
  - First reel-k step occurs at edge S+DIV_k.
  - Subsequent steps occur every DIV_k edges.
- `stop_p` sampled at edge N:
  - Digit is frozen from N onward.
  - `ref_sign` is high during cycle N..N+1.
  - For the third stop, `turn_p` is high during cycle N+1..N+2.
- Minimum start-to-`turn_p` latency is 4 cycles (stops on three consecutive edges S+1..S+3).

## Structure
- **Shared package `bandit_pkg`:**
  - FSM state enum (IDLE, SPIN3, SPIN2, SPIN1, DONE).
  - Constant `DIGIT_MAX = 4'd9`.
  - Reel-index constants `REEL1..REEL3 = 2'd1..2'd3`.
  - `Score` also imports this package.
- **Sub-module `reel_counter`:** one natural sub-module, instantiated three times. Ports: `clk`, `rst`, `clear`, `run`, `div`; outputs `digit[3:0]`. It contains the divider plus the mod-10 digit.
- **Top level:** FSM, stop sequencing and pulse registers.

## Test plan
All scenarios use `DIV_BASE=4`; start is sampled at edge S.
- **Reset values:** `rst` held 3 cycles, then released → all outputs 0, `busy=0`. `stop_p` alone then produces no `ref_sign`.
- **Wrap and relative rates:** start at S, no stops, observe at edge S+40 → `number1=0` (10 steps, wrapped), `number2=8`, `number3=6`, `busy=1`.
- **Full stop sequence:** start at S, stops at S+21, S+23, S+31 →
  - first `ref_sign` with `refresh=1` and `number1=5`;
  - second with `refresh=2` and `number2=4`;
  - third with `refresh=3` and `number3=5`;
  - `turn_p` exactly one cycle after the third `ref_sign`;
  - `busy=0` from S+32.
- **Stop-tick coincidence:** stop at S+8, which is a reel-1 tick → `number1=1`, not 2.
- **Ignored inputs:**
  - `start_p` during SPIN2 → no effect on digits or `refresh`.
  - Simultaneous `start_p`+`stop_p` in IDLE → enters SPIN3, no `ref_sign`.
- **Reset mid-spin:** assert `rst` during SPIN1 → next cycle all outputs 0, FSM in IDLE, no `turn_p` emitted afterward.

Source files
------------

// File: rtl/bandit_pkg.sv
// Shared types and constants for the one-arm bandit datapath.
// Imported by reel_spinner, reel_counter and the downstream Score stage.
package bandit_pkg;

  // Reels are frozen in order 1, 2, 3; each SPINn state names how many reels still spin.
  typedef enum logic [2:0] {
    IDLE,
    SPIN3,
    SPIN2,
    SPIN1,
    DONE
  } state_e;

  localparam logic [3:0] DIGIT_MAX = 4'd9;

  localparam logic [1:0] REEL1 = 2'd1;
  localparam logic [1:0] REEL2 = 2'd2;
  localparam logic [1:0] REEL3 = 2'd3;

endpackage

// File: rtl/reel_counter.sv
// One reel: a clock divider that steps a mod-10 digit once every `div` cycles.
// Ports:
//   clk   - system clock
//   rst   - synchronous active-high reset (counter and digit to 0)
//   clear - restart the divider from 0; the digit is kept
//   run   - reel is spinning this cycle; when low both counter and digit hold
//   div   - cycles per digit step (>= 2)
//   digit - current reel digit, 0..9
module reel_counter
  import bandit_pkg::*;
#(
  parameter int unsigned CntW = 22
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            run,
  input  logic [CntW-1:0] div,
  output logic [3:0]      digit
);

  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      digit_q, digit_d;

  always_comb begin
    cnt_d   = cnt_q;
    digit_d = digit_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      if (cnt_q == div - CntOne) begin
        cnt_d   = '0;
        digit_d = (digit_q == DIGIT_MAX) ? 4'd0 : digit_q + 4'd1;
      end else begin
        cnt_d = cnt_q + CntOne;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      digit_q <= 4'd0;
    end else begin
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
    end
  end

  assign digit = digit_q;

endmodule

// File: rtl/reel_spinner.sv
// Three-reel spin engine: free-runs three decimal reels at slightly different
// rates after start_p and freezes them in order 1, 2, 3 on successive stop_p.
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   start_p, stop_p  - one-cycle request pulses
//   number1..3       - reel digits (0..9)
//   refresh          - index of the most recently stopped reel, 0 if none since start
//   ref_sign         - one-cycle pulse when a reel stops
//   turn_p           - one-cycle pulse one cycle after the third stop
//   busy             - high while any reel spins
module reel_spinner
  import bandit_pkg::*;
#(
  parameter int unsigned DIV_BASE = 2_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_p,
  input  logic       stop_p,
  output logic [3:0] number1,
  output logic [3:0] number2,
  output logic [3:0] number3,
  output logic [1:0] refresh,
  output logic       ref_sign,
  output logic       turn_p,
  output logic       busy
);

  localparam int unsigned CntW = $clog2(DIV_BASE + 3);

  localparam logic [CntW-1:0] Div1 = CntW'(DIV_BASE);
  localparam logic [CntW-1:0] Div2 = CntW'(DIV_BASE + 1);
  localparam logic [CntW-1:0] Div3 = CntW'(DIV_BASE + 2);

  state_e     state_q, state_d;
  logic       ref_sign_q, ref_sign_d;
  logic [1:0] refresh_q, refresh_d;
  logic       turn_p_q, turn_p_d;
  logic       busy_q, busy_d;

  logic       clear;
  logic       stop_hit;
  logic [1:0] stop_idx;
  logic       run1, run2, run3;

  always_comb begin
    state_d  = state_q;
    clear    = 1'b0;
    stop_hit = 1'b0;
    stop_idx = 2'd0;
    unique case (state_q)
      IDLE: begin
        // start beats a simultaneous stop; the stop is simply dropped
        if (start_p) begin
          state_d = SPIN3;
          clear   = 1'b1;
        end
      end
      SPIN3: begin
        if (stop_p) begin
          state_d  = SPIN2;
          stop_hit = 1'b1;
          stop_idx = REEL1;
        end
      end
      SPIN2: begin
        if (stop_p) begin
          state_d  = SPIN1;
          stop_hit = 1'b1;
          stop_idx = REEL2;
        end
      end
      SPIN1: begin
        if (stop_p) begin
          state_d  = DONE;
          stop_hit = 1'b1;
          stop_idx = REEL3;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The reel being stopped must not step on the stop edge, even on a tick.
  always_comb begin
    run1 = (state_q == SPIN3) && !stop_p;
    run2 = (state_q == SPIN3) || ((state_q == SPIN2) && !stop_p);
    run3 = (state_q == SPIN3) || (state_q == SPIN2) || ((state_q == SPIN1) && !stop_p);
  end

  always_comb begin
    ref_sign_d = stop_hit;
    refresh_d  = refresh_q;
    if (clear) begin
      refresh_d = 2'd0;
    end else if (stop_hit) begin
      refresh_d = stop_idx;
    end
    turn_p_d = (state_q == DONE);
    busy_d   = (state_d == SPIN3) || (state_d == SPIN2) || (state_d == SPIN1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ref_sign_q <= 1'b0;
      refresh_q  <= 2'd0;
      turn_p_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ref_sign_q <= ref_sign_d;
      refresh_q  <= refresh_d;
      turn_p_q   <= turn_p_d;
      busy_q     <= busy_d;
    end
  end

  reel_counter #(
    .CntW (CntW)
  ) u_reel1 (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .run   (run1),
    .div   (Div1),
    .digit (number1)
  );

  reel_counter #(
    .CntW (CntW)
  ) u_reel2 (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .run   (run2),
    .div   (Div2),
    .digit (number2)
  );

  reel_counter #(
    .CntW (CntW)
  ) u_reel3 (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .run   (run3),
    .div   (Div3),
    .digit (number3)
  );

  assign ref_sign = ref_sign_q;
  assign refresh  = refresh_q;
  assign turn_p   = turn_p_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_reel_spinner.sv
// Scoreboard bench for reel_spinner with DIV_BASE = 4 (reel rates 4, 5, 6).
// Expected stop events are pushed when stop_p is driven and popped when
// ref_sign / turn_p appear. Inputs change and outputs are sampled on negedges.
module tb_reel_spinner;

  localparam int unsigned DivBase = 4;

  logic       clk;
  logic       rst;
  logic       start_p;
  logic       stop_p;
  logic [3:0] number1, number2, number3;
  logic [1:0] refresh;
  logic       ref_sign;
  logic       turn_p;
  logic       busy;

  reel_spinner #(
    .DIV_BASE (DivBase)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start_p  (start_p),
    .stop_p   (stop_p),
    .number1  (number1),
    .number2  (number2),
    .number3  (number3),
    .refresh  (refresh),
    .ref_sign (ref_sign),
    .turn_p   (turn_p),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Number of rising edges seen so far; read on negedges it names the last edge.
  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    int edge_n;
    int reel;
    int digit;
  } exp_t;

  exp_t ref_q[$];
  int   turn_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  int s_edge;
  int next_reel;
  int cur_dig[1:3];

  task automatic check_eq(input string tag, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, act, exp, edge_cnt);
    end
  endtask

  function automatic int reel_num(input int k);
    case (k)
      1:       return int'(number1);
      2:       return int'(number2);
      default: return int'(number3);
    endcase
  endfunction

  // Monitor: every ref_sign / turn_p must match the head of its queue.
  exp_t e;
  int   te;
  always @(negedge clk) begin
    if (ref_sign) begin
      if (ref_q.size() == 0) begin
        check_eq("ref_sign_spurious", 1, 0);
      end else begin
        e = ref_q.pop_front();
        check_eq("ref_edge", edge_cnt, e.edge_n);
        check_eq("ref_refresh", int'(refresh), e.reel);
        check_eq("ref_digit", reel_num(e.reel), e.digit);
      end
    end
    if (turn_p) begin
      if (turn_q.size() == 0) begin
        check_eq("turn_p_spurious", 1, 0);
      end else begin
        te = turn_q.pop_front();
        check_eq("turn_edge", edge_cnt, te);
        check_eq("turn_num1", int'(number1), cur_dig[1]);
        check_eq("turn_num2", int'(number2), cur_dig[2]);
        check_eq("turn_num3", int'(number3), cur_dig[3]);
        check_eq("turn_busy", int'(busy), 0);
      end
    end
  end

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) cur_dig[k] = 0;
    next_reel = 1;
  endtask

  // Start pulse (optionally with stop_p), sampled on the next edge S.
  task automatic do_start(input logic with_stop);
    start_p = 1'b1;
    stop_p  = with_stop;
    @(negedge clk);
    start_p   = 1'b0;
    stop_p    = 1'b0;
    s_edge    = edge_cnt;
    next_reel = 1;
  endtask

  // Stop pulse sampled at absolute edge n; pushes the predicted stop event.
  task automatic do_stop_at(input int n);
    int k;
    int div;
    int dig;
    while (edge_cnt < n - 1) @(negedge clk);
    k   = next_reel;
    div = int'(DivBase) + k - 1;
    // steps taken on edges S+div*j strictly before the stop edge
    dig = (cur_dig[k] + (n - s_edge - 1) / div) % 10;
    ref_q.push_back('{edge_n: n, reel: k, digit: dig});
    cur_dig[k] = dig;
    if (k == 3) turn_q.push_back(n + 1);
    next_reel++;
    stop_p = 1'b1;
    @(negedge clk);
    stop_p = 1'b0;
  endtask

  task automatic wait_edge(input int n);
    while (edge_cnt < n) @(negedge clk);
  endtask

  initial begin
    rst     = 1'b0;
    start_p = 1'b0;
    stop_p  = 1'b0;
    @(negedge clk);

    // Reset values, then a lone stop in IDLE does nothing
    do_reset(3);
    check_eq("rst_num1", int'(number1), 0);
    check_eq("rst_num2", int'(number2), 0);
    check_eq("rst_num3", int'(number3), 0);
    check_eq("rst_refresh", int'(refresh), 0);
    check_eq("rst_ref_sign", int'(ref_sign), 0);
    check_eq("rst_turn_p", int'(turn_p), 0);
    check_eq("rst_busy", int'(busy), 0);
    stop_p = 1'b1;
    @(negedge clk);
    stop_p = 1'b0;
    @(negedge clk);
    check_eq("idle_stop_busy", int'(busy), 0);

    // Wrap and relative rates: 40 cycles gives 10, 8 and 6 steps
    do_start(1'b0);
    check_eq("start_busy", int'(busy), 1);
    wait_edge(s_edge + 40);
    check_eq("wrap_num1", int'(number1), (cur_dig[1] + 40 / 4) % 10);
    check_eq("wrap_num2", int'(number2), (cur_dig[2] + 40 / 5) % 10);
    check_eq("wrap_num3", int'(number3), (cur_dig[3] + 40 / 6) % 10);
    check_eq("wrap_busy", int'(busy), 1);
    do_stop_at(s_edge + 41);
    do_stop_at(s_edge + 42);
    do_stop_at(s_edge + 43);
    repeat (3) @(negedge clk);
    check_eq("turn1_refresh_hold", int'(refresh), 3);

    // Full stop sequence, with a start pulse ignored during SPIN2
    do_start(1'b0);
    check_eq("start_clears_refresh", int'(refresh), 0);
    do_stop_at(s_edge + 21);
    start_p = 1'b1;
    @(negedge clk);
    start_p = 1'b0;
    check_eq("spin2_start_refresh", int'(refresh), 1);
    check_eq("spin2_start_num1", int'(number1), cur_dig[1]);
    check_eq("spin2_start_busy", int'(busy), 1);
    do_stop_at(s_edge + 23);
    do_stop_at(s_edge + 31);
    wait_edge(s_edge + 32);
    check_eq("seq_busy_after", int'(busy), 0);
    repeat (3) @(negedge clk);

    // Stop coincides with a reel-1 tick: the tick is suppressed
    do_reset(1);
    do_start(1'b0);
    do_stop_at(s_edge + 8);
    check_eq("coincide_num1", int'(number1), 1);
    do_stop_at(s_edge + 9);
    do_stop_at(s_edge + 10);
    repeat (3) @(negedge clk);

    // start+stop together in IDLE: start wins, then minimum-latency turn
    do_start(1'b1);
    check_eq("simul_busy", int'(busy), 1);
    check_eq("simul_ref_sign", int'(ref_sign), 0);
    check_eq("simul_refresh", int'(refresh), 0);
    do_stop_at(s_edge + 1);
    do_stop_at(s_edge + 2);
    do_stop_at(s_edge + 3);
    repeat (3) @(negedge clk);

    // Reset during SPIN1: everything back to zero, no turn_p afterward
    do_start(1'b0);
    do_stop_at(s_edge + 3);
    do_stop_at(s_edge + 5);
    wait_edge(s_edge + 6);
    check_eq("midspin_busy_before", int'(busy), 1);
    do_reset(1);
    check_eq("midspin_num1", int'(number1), 0);
    check_eq("midspin_num2", int'(number2), 0);
    check_eq("midspin_num3", int'(number3), 0);
    check_eq("midspin_refresh", int'(refresh), 0);
    check_eq("midspin_busy", int'(busy), 0);
    check_eq("midspin_ref_sign", int'(ref_sign), 0);
    check_eq("midspin_turn_p", int'(turn_p), 0);
    stop_p = 1'b1;
    @(negedge clk);
    stop_p = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("midspin_idle_busy", int'(busy), 0);

    check_eq("sb_ref_pending", ref_q.size(), 0);
    check_eq("sb_turn_pending", turn_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
